decoder_sched: RTL and testbench

- Round-robin scheduler that shares one parity `decoder` instance between NUM_CH receive channels.
- Each channel offers a 9-bit frame (8 data bits plus 1 parity bit) through a valid/ready handshake.
- The scheduler grants one channel, drives the frame into the decoder, and captures the registered byte and error result one cycle later.
- It returns the result with the channel index on a single valid/ready output port. It sits between the per-channel deserialisers and the byte sink of the transceiver.

---
 rtl/decoder_sched_pkg.sv | 16 +
 rtl/decoder.sv | 16 +
 rtl/decoder_sched_rr_arbiter.sv | 27 ++
 rtl/decoder_sched.sv | 135 +++++++++++++
 tb/tb_decoder_sched.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_sched_pkg.sv
// Shared types for decoder_sched: FSM state encoding and frame-width helper.
package decoder_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } sched_state_t;

    // Frame is payload plus one parity bit in the MSB.
    function automatic int unsigned frame_w(input int unsigned data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/decoder.sv
// Registered even-parity frame decoder; flops carry no reset.
module decoder #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH:0]   in_data,
    output logic [DATA_WIDTH-1:0] out_byte,
    output logic                  err
);

    always_ff @(posedge clk) begin
        out_byte <= in_data[DATA_WIDTH-1:0];
        err      <= ^in_data;
    end

endmodule

// File: rtl/decoder_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request after last_grant, with wrap.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx
);

    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = 0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = (32'(last_grant) + i) % NUM_CH;
            if (grant == '0 && req[CH_W'(cand)]) begin
                grant[CH_W'(cand)] = 1'b1;
                idx                = CH_W'(cand);
            end
        end
    end

endmodule

// File: rtl/decoder_sched.sv
// Round-robin scheduler sharing one parity decoder across NUM_CH channels.
// Optional per-channel error counters: define DECODER_SCHED_ERR_CNT_EN.
module decoder_sched
    import decoder_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CH_W       = $clog2(NUM_CH)
`ifdef DECODER_SCHED_ERR_CNT_EN
    ,
    parameter int unsigned CNT_W      = 8
`endif
) (
    input  logic                                clk,
    input  logic                                arst,
    input  logic [NUM_CH*(DATA_WIDTH+1)-1:0]    in_data,
    input  logic [NUM_CH-1:0]                   in_valid,
    output logic [NUM_CH-1:0]                   in_ready,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [CH_W-1:0]                     out_ch,
    output logic [DATA_WIDTH-1:0]               out_byte,
    output logic                                out_err,
`ifdef DECODER_SCHED_ERR_CNT_EN
    input  logic                                err_clr,
    output logic [NUM_CH*CNT_W-1:0]             err_cnt,
`endif
    output logic                                busy
);

    localparam int unsigned FW = frame_w(DATA_WIDTH);

    sched_state_t           state;
    logic [FW-1:0]          hold_q;
    logic [CH_W-1:0]        ch_q;
    logic [CH_W-1:0]        last_grant;
    logic [NUM_CH-1:0]      grant;
    logic [CH_W-1:0]        grant_idx;
    logic [FW-1:0]          frame_sel;
    logic [DATA_WIDTH-1:0]  dec_byte;
    logic                   dec_err;

    rr_arbiter #(
        .NUM_CH     (NUM_CH),
        .CH_W       (CH_W)
    ) u_arb (
        .req        (in_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .idx        (grant_idx)
    );

    decoder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dec (
        .clk        (clk),
        .in_data    (hold_q),
        .out_byte   (dec_byte),
        .err        (dec_err)
    );

    // Frame of the granted channel.
    always_comb begin
        frame_sel = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (grant[k]) frame_sel = in_data[k*FW +: FW];
        end
    end

    // Accept is only offered while idle; the handshake completes on that edge.
    assign in_ready = (state == IDLE) ? grant : '0;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= IDLE;
            hold_q     <= '0;
            ch_q       <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_byte   <= '0;
            out_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        hold_q     <= frame_sel;
                        ch_q       <= grant_idx;
                        last_grant <= grant_idx;
                        busy       <= 1'b1;
                        state      <= DEC;
                    end
                end
                DEC: state <= WAIT;
                WAIT: begin
                    // A failed frame never forwards the decoder's stale byte.
                    out_err   <= dec_err;
                    out_byte  <= dec_err ? '0 : dec_byte;
                    out_ch    <= ch_q;
                    out_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DECODER_SCHED_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    // Saturating per-channel error counters; clear beats increment.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int k = 0; k < int'(NUM_CH); k++) cnt_q[k] <= '0;
        end else if (err_clr) begin
            for (int k = 0; k < int'(NUM_CH); k++) cnt_q[k] <= '0;
        end else if (state == WAIT && dec_err && cnt_q[ch_q] != '1) begin
            cnt_q[ch_q] <= cnt_q[ch_q] + 1'b1;
        end
    end

    for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_cnt
        assign err_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_decoder_sched.sv
// Scoreboard bench for decoder_sched: transaction-level round-robin/parity model.
module tb_decoder_sched;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int FW  = DW + 1;
    localparam int TB_CNT_W = 2;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic [NCH*FW-1:0] in_data;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [1:0]        out_ch;
    logic [DW-1:0]     out_byte;
    logic              out_err;
    logic              busy;
`ifdef DECODER_SCHED_ERR_CNT_EN
    logic                    err_clr = 1'b0;
    logic [NCH*TB_CNT_W-1:0] err_cnt;
    int                      mcnt [NCH];
`endif

    decoder_sched #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .CH_W       (2)
`ifdef DECODER_SCHED_ERR_CNT_EN
        ,
        .CNT_W      (TB_CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_byte  (out_byte),
        .out_err   (out_err),
`ifdef DECODER_SCHED_ERR_CNT_EN
        .err_clr   (err_clr),
        .err_cnt   (err_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [7:0] b;
        logic       e;
        int         acc;
    } exp_t;

    exp_t       sbq [$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [3:0] pend_v = '0;
    logic [8:0] pend_d [NCH];
    int         model_last = NCH - 1;
    bit         busy_m = 0;
    bit         acc_pending = 0;
    int         acc_ch = 0;
    bit         rel_pending = 0;
    bit         auto_mode = 0;
    bit         rand_or = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        in_valid = pend_v;
        in_data  = '0;
        for (int k = 0; k < NCH; k++) in_data[k*FW +: FW] = pend_d[k];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round-robin rule: first requester after the previous winner, wrapping.
    function automatic int model_grant(input logic [3:0] v, input int last);
        for (int i = 1; i <= NCH; i++) begin
            if (v[(last + i) % NCH]) return (last + i) % NCH;
        end
        return -1;
    endfunction

    // Driver: predicts grants and pushes expected results.
    initial begin : driver
        int   g;
        exp_t e;
        for (int k = 0; k < NCH; k++) pend_d[k] = '0;
        forever begin
            @(negedge clk);
            if (!arst) begin
                chk("busy", 32'(busy), 32'(busy_m));
                if (busy_m || pend_v == '0) begin
                    chk("in_ready_zero", 32'(in_ready), 32'(0));
                end else begin
                    g = model_grant(pend_v, model_last);
                    chk("in_ready_grant", 32'(in_ready), 32'(1) << g);
                    e.ch  = g;
                    e.e   = ^pend_d[g];
                    e.b   = e.e ? 8'h00 : pend_d[g][7:0];
                    e.acc = cyc;
                    sbq.push_back(e);
                    model_last  = g;
                    busy_m      = 1;
                    acc_ch      = g;
                    acc_pending = 1;
                end
            end
            @(posedge clk);
            #1;
            if (acc_pending) begin
                pend_v[acc_ch] = 1'b0;
                acc_pending    = 0;
            end
            if (rel_pending) begin
                busy_m      = 0;
                rel_pending = 0;
            end
            if (auto_mode) begin
                for (int k = 0; k < NCH; k++) begin
                    if (!pend_v[k] && $urandom_range(0, 3) == 0) begin
                        pend_d[k] = 9'($urandom);
                        pend_v[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Random sink backpressure.
    initial begin : sink
        forever begin
            @(posedge clk);
            #1;
            if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares every presented result against the scoreboard.
    initial begin : monitor
        bit         stall = 0;
        logic [1:0] p_ch;
        logic [7:0] p_b;
        logic       p_e;
        exp_t       x;
        forever begin
            @(negedge clk);
            if (arst) begin
                stall = 0;
            end else if (out_valid) begin
                if (stall) begin
                    chk("hold_ch", 32'(out_ch), 32'(p_ch));
                    chk("hold_byte", 32'(out_byte), 32'(p_b));
                    chk("hold_err", 32'(out_err), 32'(p_e));
                end else if (sbq.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'(0));
                end else begin
                    chk("latency", 32'(cyc), 32'(sbq[0].acc + 3));
                end
                if (out_ready) begin
                    if (sbq.size() != 0) begin
                        x = sbq.pop_front();
                        chk("out_ch", 32'(out_ch), 32'(x.ch));
                        chk("out_byte", 32'(out_byte), 32'(x.b));
                        chk("out_err", 32'(out_err), 32'(x.e));
`ifdef DECODER_SCHED_ERR_CNT_EN
                        if (x.e && mcnt[x.ch] < (2**TB_CNT_W - 1)) mcnt[x.ch]++;
`endif
                    end
                    rel_pending = 1;
                    stall       = 0;
                end else begin
                    stall = 1;
                    p_ch  = out_ch;
                    p_b   = out_byte;
                    p_e   = out_err;
                end
            end else begin
                stall = 0;
            end
        end
    end

    task automatic offer(input int ch, input logic [8:0] d);
        pend_d[ch] = d;
        pend_v[ch] = 1'b1;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #2;
            if (sbq.size() == 0 && !busy_m && pend_v == '0) return;
        end
        chk("drain_timeout", 32'(sbq.size()), 32'(0));
    endtask

    task automatic wait_accept();
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #2;
            if (busy_m) return;
        end
        chk("accept_timeout", 32'(busy_m), 32'(1));
    endtask

    initial begin : main
`ifdef DECODER_SCHED_ERR_CNT_EN
        for (int k = 0; k < NCH; k++) mcnt[k] = 0;
`endif
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_ch", 32'(out_ch), 32'(0));
        chk("rst_out_byte", 32'(out_byte), 32'(0));
        chk("rst_out_err", 32'(out_err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        repeat (3) @(posedge clk);
        #2 arst = 1'b0;

        // Good and bad parity frames.
        offer(0, 9'h0A5);
        wait_drain();
        offer(2, 9'h1A5);
        wait_drain();

        // All four contend, then two.
        for (int k = 0; k < NCH; k++) offer(k, 9'($urandom));
        wait_drain();
        offer(0, 9'h0C3);
        offer(2, 9'h101);
        wait_drain();

        // Sink stalls five cycles in RESP.
        out_ready = 1'b0;
        offer(1, 9'h0FF);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #2;
            if (out_valid) break;
        end
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain();

        // Random traffic with random backpressure.
        rand_or   = 1;
        auto_mode = 1;
        repeat (1500) @(posedge clk);
        #2 auto_mode = 0;
        wait_drain();
        rand_or   = 0;
        out_ready = 1'b1;

        // Reset asserted while the frame sits in WAIT.
        offer(3, 9'h13C);
        wait_accept();
        @(posedge clk);
        #2 arst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'(0));
        chk("arst_out_valid", 32'(out_valid), 32'(0));
        chk("arst_out_ch", 32'(out_ch), 32'(0));
        chk("arst_out_byte", 32'(out_byte), 32'(0));
        chk("arst_out_err", 32'(out_err), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        sbq.delete();
        busy_m      = 0;
        acc_pending = 0;
        rel_pending = 0;
        model_last  = NCH - 1;
        pend_v      = '0;
`ifdef DECODER_SCHED_ERR_CNT_EN
        for (int k = 0; k < NCH; k++) mcnt[k] = 0;
`endif
        repeat (2) @(posedge clk);
        #2 arst = 1'b0;
        offer(1, 9'h011);
        offer(0, 9'h022);
        wait_drain();

`ifdef DECODER_SCHED_ERR_CNT_EN
        for (int n = 0; n < 5; n++) begin
            offer(1, 9'h1A5);
            wait_drain();
        end
        for (int k = 0; k < NCH; k++)
            chk("err_cnt", 32'(err_cnt[k*TB_CNT_W +: TB_CNT_W]), 32'(mcnt[k]));
        // Clear coincident with a failing frame in WAIT.
        offer(1, 9'h1A5);
        wait_accept();
        @(posedge clk);
        #2 err_clr = 1'b1;
        @(posedge clk);
        #2 err_clr = 1'b0;
        wait_drain();
        for (int k = 0; k < NCH; k++) mcnt[k] = 0;
        for (int k = 0; k < NCH; k++)
            chk("err_cnt_clr", 32'(err_cnt[k*TB_CNT_W +: TB_CNT_W]), 32'(mcnt[k]));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
